mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store sequencer directly upstream of Data_Memory in the MEM stage. Accepts one
//  pipeline request at a time (valid/ready), runs byte/half/word loads and stores against
//  the word-wide Data_Memory port, and returns extended load data or a fault.
//  Sub-word stores are done as read-modify-write.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width of req_addr / mem_address
//  DATA_WIDTH  32  data width; fixed at 32, any other value is unsupported
// PORTS
//  CLK            in   1   clock, all state updates on posedge
//  RST            in   1   synchronous, active-high reset
//  req_valid      in   1   request present
//  req_ready      out  1   unit can accept a request this cycle
//  req_write      in   1   1 = store, 0 = load
//  req_size       in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_signed     in   1   load sign-extend enable (ignored for stores)
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid     out  1   one-cycle response strobe
//  resp_rdata     out  32  extended load data; 0 for stores and faults
//  resp_fault     out  1   request rejected, no memory access made
//  mem_address    out  32  to Data_Memory address, always word aligned ([1:0]=00)
//  mem_writeData  out  32  to Data_Memory writeData
//  mem_memWrite   out  1   to Data_Memory memWrite
//  mem_memRead    out  1   to Data_Memory memRead
//  mem_readData   in   32  from Data_Memory readData, valid in the same cycle as mem_memRead
// BEHAVIOUR
//  - FSM states: IDLE, READ, WRITE, RESP. Reset -> IDLE. While RST=1, every output is 0,
//    including req_ready. req_ready=1 only in IDLE with RST=0.
//  - Accept = req_valid & req_ready. All req_* fields are latched on accept. One request
//    is outstanding at most.
//  - From IDLE on accept:
//    load -> READ. Word store -> WRITE. Byte/half store -> READ.
//    Fault -> RESP; no mem_* activity for a fault.
//  - READ: mem_memRead=1. On the edge, capture mem_readData.
//    Load: register the extracted, extended data, then go to RESP.
//    Sub-word store: build the merged word, then go to WRITE.
//  - WRITE: mem_memWrite=1 with mem_writeData = full word or merged word, then go to RESP.
//    mem_memWrite is gated by !RST.
//  - RESP: resp_valid=1 for exactly one cycle (no backpressure), then IDLE.
//    req_ready returns the cycle after RESP.
//  - Latency, accept edge to resp_valid high: load 2 cycles, word store 2, sub-word store 3,
//    fault 1.
//  - Endianness is little: lane = addr[1:0] for a byte, addr[1] for a half.
//    Merge replaces only the addressed lane(s).
//    Load extension: zero-extend, or sign-extend from lane MSB when req_signed=1.
//  - mem_address = {addr[31:2],2'b00} during READ/WRITE, else 0.
//    mem_writeData = 0 outside WRITE.
//  - req_size=11 always faults: resp_fault=1, resp_rdata=0.
//  - Reset mid-operation aborts the request: no pending write is issued, no response is
//    produced, FSM is in IDLE after the reset edge.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//    Half with addr[0]=1, or word with addr[1:0]!=00, faults (1-cycle fault path above).
//  LSU_MISALIGN_TRAP_EN undefined:
//    No misalign fault. Half uses addr[1] and ignores addr[0]; word ignores addr[1:0].
//    Only size 11 faults.
// TESTING
//  1. RST=1 for 2 cycles -> req_ready, resp_valid and all mem_* = 0.
//     After release -> req_ready=1.
//  2. Word store addr 0x08, wdata 0x00000004 -> one WRITE cycle (address 0x08, writeData 0x4);
//     resp_valid 2 cycles after accept; fault=0; rdata=0.
//  3. Mem[0x0C]=0x11223344; byte store addr 0x0E, wdata 0xAB -> READ cycle, then WRITE
//     0x11AB3344 to 0x0C; resp_valid at 3 cycles.
//  4. Mem[0x0C]=0x11AB3344. Byte load 0x0E signed -> 0xFFFFFFAB; unsigned -> 0x000000AB.
//     Half load 0x0E signed -> 0x000011AB. All with memRead for 1 cycle.
//  5. Word load addr 0x0A, Mem[0x08]=0xDEADBEEF:
//     with macro -> fault=1, rdata=0, no memRead;
//     without macro -> rdata=0xDEADBEEF, fault=0.
//  6. Sub-word store with RST asserted during its WRITE cycle -> memWrite stays 0;
//     Mem unchanged; no resp_valid; req_ready=1 the cycle after RST drops.
//     Also: req_size=11 -> fault=1 at 1 cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a word-wide Data_Memory: byte/half/word loads, stores, RMW sub-word stores.
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of ignoring low address bits.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writeData,
    output logic                  mem_memWrite,
    output logic                  mem_memRead,
    input  logic [DATA_WIDTH-1:0] mem_readData
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_WRITE = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_accept;
    logic                    w_fault;
    logic                    r_write;
    logic [1:0]              r_size;
    logic                    r_signed;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_fault;

    // Shift amount selecting the addressed lane; half lanes ignore addr[0].
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [4:0] sh;
        case (size)
            2'b00:   sh = {addr_lo, 3'b000};
            2'b01:   sh = {addr_lo[1], 4'b0000};
            default: sh = 5'd0;
        endcase
        return sh;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            size,
        input logic [1:0]            addr_lo,
        input logic                  sgn
    );
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] res;
        sh = word >> lane_shift(size, addr_lo);
        case (size)
            2'b00:   res = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   res = {{16{sgn & sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_merge(
        input logic [DATA_WIDTH-1:0] word,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [1:0]            size,
        input logic [1:0]            addr_lo
    );
        logic [DATA_WIDTH-1:0] mask;
        logic [4:0]            sh;
        sh   = lane_shift(size, addr_lo);
        mask = (size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        return (word & ~(mask << sh)) | ((wdata & mask) << sh);
    endfunction

    always_comb begin
        w_fault = (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_size == 2'b01 && req_addr[0])
            w_fault = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            w_fault = 1'b1;
`endif
    end

    assign w_accept = req_valid & req_ready;

    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Every output is forced low while RST is high, which also suppresses a pending write.
    always_comb begin
        w_next        = r_state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_fault    = 1'b0;
        mem_address   = '0;
        mem_writeData = '0;
        mem_memWrite  = 1'b0;
        mem_memRead   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_fault)
                        w_next = S_RESP;
                    else if (req_write && req_size == 2'b10)
                        w_next = S_WRITE;
                    else
                        w_next = S_READ;
                end
            end
            S_READ: begin
                mem_memRead = 1'b1;
                mem_address = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                w_next      = r_write ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                mem_memWrite  = 1'b1;
                mem_address   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                mem_writeData = r_wdata;
                w_next        = S_RESP;
            end
            default: begin
                resp_valid = 1'b1;
                resp_rdata = r_rdata;
                resp_fault = r_fault;
                w_next     = S_IDLE;
            end
        endcase
        if (RST) begin
            req_ready     = 1'b0;
            resp_valid    = 1'b0;
            resp_rdata    = '0;
            resp_fault    = 1'b0;
            mem_address   = '0;
            mem_writeData = '0;
            mem_memWrite  = 1'b0;
            mem_memRead   = 1'b0;
        end
    end

    // Request fields and result words carry no reset; they are only observed in READ/WRITE/RESP.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= '0;
            r_fault  <= w_fault;
        end else if (r_state == S_READ) begin
            if (r_write)
                r_wdata <= store_merge(mem_readData, r_wdata, r_size, r_addr[1:0]);
            else
                r_rdata <= load_extend(mem_readData, r_size, r_addr[1:0], r_signed);
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-lane reference model, behavioural Data_Memory, directed plus random traffic.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_memWrite;
    logic        mem_memRead;
    logic [31:0] mem_readData;

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead), .mem_readData(mem_readData)
    );

    always #5 CLK = ~CLK;

    // Behavioural Data_Memory (16 words) with a backdoor preload port
    logic [31:0] dmem [16];
    logic [31:0] ref_mem [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [31:0] pl_data = 32'd0;

    assign mem_readData = dmem[mem_address[5:2]];

    always @(posedge CLK) begin
        if (mem_memWrite)
            dmem[mem_address[5:2]] <= mem_writeData;
        else if (pl_en)
            dmem[pl_idx] <= pl_data;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          acc;
        int          reads;
        logic [31:0] waddr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    exp_t sb[$];
    wr_t  wq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rd_cnt  = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    function automatic void fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event, expected none", nm);
    endfunction

    // Reference model: works byte by byte on the word image kept in ref_mem.
    function automatic void model(input logic wr, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output exp_t e, output bit has_w, output wr_t w);
        int          nb;
        int          off;
        int          wi;
        bit          mis;
        logic [31:0] word;
        logic [31:0] val;
        e.waddr = {addr[31:2], 2'b00};
        e.acc   = 0;
        wi      = int'(addr[5:2]);
        has_w   = 0;
        w.addr  = e.waddr;
        w.data  = 32'd0;
        mis     = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
`endif
        if (size == 2'd3 || mis) begin
            e.rdata = 32'd0; e.fault = 1'b1; e.lat = 1; e.reads = 0;
            return;
        end
        nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off     = (size == 2'd0) ? int'(addr[1:0]) : (size == 2'd1) ? 2 * int'(addr[1]) : 0;
        word    = ref_mem[wi];
        e.fault = 1'b0;
        if (!wr) begin
            val = 32'd0;
            for (int i = 0; i < nb; i++) val[8*i +: 8] = word[8*(off+i) +: 8];
            if (sgn && nb < 4 && val[8*nb-1])
                for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
            e.rdata = val; e.lat = 2; e.reads = 1;
        end else begin
            for (int i = 0; i < nb; i++) word[8*(off+i) +: 8] = wdata[8*i +: 8];
            ref_mem[wi] = word;
            has_w  = 1;
            w.data = word;
            e.rdata = 32'd0;
            e.lat   = (nb == 4) ? 2 : 3;
            e.reads = (nb == 4) ? 0 : 1;
        end
    endfunction

    // Monitor: pops and compares whenever the DUT presents activity
    initial begin
        exp_t e;
        wr_t  w;
        forever begin
            @(negedge CLK);
            if (RST) begin
                rd_cnt = 0;
                check("rst_ready", 32'(req_ready), 32'd0);
                check("rst_resp_valid", 32'(resp_valid), 32'd0);
                check("rst_memRead", 32'(mem_memRead), 32'd0);
                check("rst_memWrite", 32'(mem_memWrite), 32'd0);
                check("rst_address", mem_address, 32'd0);
                check("rst_writeData", mem_writeData, 32'd0);
            end else begin
                check("ready", 32'(req_ready), (sb.size() == 0) ? 32'd1 : 32'd0);
                if (mem_memRead) begin
                    rd_cnt++;
                    if (sb.size() == 0) fail_now("unexpected_read");
                    else check("read_addr", mem_address, sb[0].waddr);
                end
                if (mem_memWrite) begin
                    if (wq.size() == 0) fail_now("unexpected_write");
                    else begin
                        w = wq.pop_front();
                        check("write_addr", mem_address, w.addr);
                        check("write_data", mem_writeData, w.data);
                    end
                end
                if (!mem_memRead && !mem_memWrite) begin
                    check("idle_address", mem_address, 32'd0);
                    check("idle_writeData", mem_writeData, 32'd0);
                end
                if (resp_valid) begin
                    if (sb.size() == 0) fail_now("unexpected_resp");
                    else begin
                        e = sb.pop_front();
                        check("resp_rdata", resp_rdata, e.rdata);
                        check("resp_fault", 32'(resp_fault), 32'(e.fault));
                        check("latency", 32'(cyc - e.acc), 32'(e.lat));
                        check("read_cycles", 32'(rd_cnt), 32'(e.reads));
                    end
                    rd_cnt = 0;
                end
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] data);
        ref_mem[idx] = data;
        @(negedge CLK);
        pl_idx  = 4'(idx);
        pl_data = data;
        pl_en   = 1'b1;
        @(posedge CLK);
        #1 pl_en = 1'b0;
    endtask

    task automatic scramble();
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit ovr, input logic [31:0] ovr_rdata);
        exp_t e;
        wr_t  w;
        bit   has_w;
        int   t;
        @(negedge CLK);
        req_valid = 1'b1; req_write = wr; req_size = size;
        req_signed = sgn; req_addr = addr; req_wdata = wdata;
        t = 0;
        while (!req_ready && t < 40) begin
            @(negedge CLK);
            t++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        model(wr, size, sgn, addr, wdata, e, has_w, w);
        if (ovr) e.rdata = ovr_rdata;
        e.acc = cyc;
        @(posedge CLK);
        sb.push_back(e);
        if (has_w) wq.push_back(w);
        #1 req_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || wq.size() != 0) && t < 40) begin
            @(negedge CLK);
            t++;
        end
        check("drain_sb", 32'(sb.size()), 32'd0);
        @(negedge CLK);
    endtask

    // Sub-word store aborted by RST during its WRITE cycle
    task automatic abort_store();
        exp_t e;
        int   t;
        preload(5, 32'hCAFE_F00D);
        @(negedge CLK);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h15; req_wdata = 32'h5A;
        t = 0;
        while (!req_ready && t < 40) begin
            @(negedge CLK);
            t++;
        end
        e.rdata = 32'd0; e.fault = 1'b0; e.lat = 3; e.acc = cyc; e.reads = 1; e.waddr = 32'h14;
        @(posedge CLK);
        sb.push_back(e);
        #1 req_valid = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 sb.delete();
        RST = 1'b0;
        @(negedge CLK);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_mem", dmem[5], 32'hCAFE_F00D);
    endtask

    initial begin
        RST = 1'b1;
        req_valid = 1'b0;
        scramble();
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("reset_release_ready", 32'(req_ready), 32'd1);

        issue(1'b1, 2'd2, 1'b0, 32'h08, 32'h4, 0, 32'd0);
        wait_idle();
        check("word_store_mem", dmem[2], 32'h4);

        preload(3, 32'h1122_3344);
        issue(1'b1, 2'd0, 1'b0, 32'h0E, 32'hAB, 0, 32'd0);
        wait_idle();
        check("byte_store_mem", dmem[3], 32'h11AB_3344);

        issue(1'b0, 2'd0, 1'b1, 32'h0E, 32'd0, 1, 32'hFFFF_FFAB);
        issue(1'b0, 2'd0, 1'b0, 32'h0E, 32'd0, 1, 32'h0000_00AB);
        issue(1'b0, 2'd1, 1'b1, 32'h0E, 32'd0, 1, 32'h0000_11AB);
        wait_idle();

        preload(2, 32'hDEAD_BEEF);
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 2'd2, 1'b0, 32'h0A, 32'd0, 1, 32'd0);
`else
        issue(1'b0, 2'd2, 1'b0, 32'h0A, 32'd0, 1, 32'hDEAD_BEEF);
`endif
        wait_idle();

        abort_store();
        issue(1'b0, 2'd3, 1'b1, 32'h04, 32'd0, 1, 32'd0);
        issue(1'b1, 2'd3, 1'b0, 32'h21, 32'h77, 0, 32'd0);
        wait_idle();

        for (int k = 0; k < 250; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                  32'($urandom_range(0, 63)), $urandom, 0, 32'd0);
        end
        wait_idle();

        for (int i = 0; i < 16; i++) check("final_mem", dmem[i], ref_mem[i]);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
